// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS and inter-packet gap
module gmii_tx_framer #(
  parameter int IPG    = 12,
  parameter int MINLEN = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic [31:0] frame_cnt,
  output logic [15:0] underrun_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_PAYLOAD  = 3'd2;
  localparam logic [2:0] S_PAD      = 3'd3;
  localparam logic [2:0] S_FCS      = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [15:0] MIN_BYTES = 16'(MINLEN);
  localparam logic [15:0] GAP_LAST  = 16'(IPG - 1);

  logic [2:0]  state;
  logic [2:0]  pre_cnt;
  logic [15:0] byte_cnt;
  logic [15:0] byte_inc;
  logic [15:0] gap_cnt;
  logic [1:0]  fcs_idx;
  logic [31:0] crc;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // The state names the byte loaded at the next edge, so in_ready is already
  // high while the SFD is on the wire and the first payload byte follows it.
  assign in_ready = (state == S_PAYLOAD);
  assign byte_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      pre_cnt      <= 3'd0;
      byte_cnt     <= 16'd0;
      gap_cnt      <= 16'd0;
      fcs_idx      <= 2'd0;
      crc          <= 32'hFFFFFFFF;
      txd          <= 8'h00;
      tx_en        <= 1'b0;
      tx_er        <= 1'b0;
      frame_cnt    <= 32'd0;
      underrun_cnt <= 16'd0;
    end else begin
      tx_er <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_en <= 1'b0;
          txd   <= 8'h00;
          if (in_valid) begin
            state    <= S_PREAMBLE;
            tx_en    <= 1'b1;
            txd      <= 8'h55;
            pre_cnt  <= 3'd1;
            byte_cnt <= 16'd0;
            fcs_idx  <= 2'd0;
            crc      <= 32'hFFFFFFFF;
          end
        end
        S_PREAMBLE: begin
          if (pre_cnt == 3'd7) begin
            txd   <= 8'hD5;
            state <= S_PAYLOAD;
          end else begin
            txd     <= 8'h55;
            pre_cnt <= pre_cnt + 3'd1;
          end
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            txd      <= in_data;
            crc      <= crc32_byte(crc, in_data);
            byte_cnt <= byte_inc;
            if (in_last)
              state <= (byte_inc < MIN_BYTES) ? S_PAD : S_FCS;
          end else begin
            // Source starved mid-frame: poison the frame and skip the FCS.
            tx_er   <= 1'b1;
            txd     <= 8'h00;
            state   <= S_GAP;
            gap_cnt <= 16'd0;
            if (underrun_cnt != 16'hFFFF)
              underrun_cnt <= underrun_cnt + 16'd1;
          end
        end
        S_PAD: begin
          txd      <= 8'h00;
          crc      <= crc32_byte(crc, 8'h00);
          byte_cnt <= byte_inc;
          if (byte_inc >= MIN_BYTES)
            state <= S_FCS;
        end
        S_FCS: begin
          txd     <= ~crc[{fcs_idx, 3'b000} +: 8];
          fcs_idx <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state     <= S_GAP;
            gap_cnt   <= 16'd0;
            frame_cnt <= frame_cnt + 32'd1;
          end
        end
        S_GAP: begin
          tx_en <= 1'b0;
          txd   <= 8'h00;
          crc   <= 32'hFFFFFFFF;
          if (gap_cnt == GAP_LAST)
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
